// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             dmem_req, dmem_ready;
    logic             InstrValidW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             mem_err;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, dmem_req, dmem_ready, InstrValidW,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_err,
               cycle_cnt, stall_cnt, flush_cnt, retire_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, dmem_req, dmem_ready, InstrValidW,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_err,
               cycle_cnt, stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - execute-operand forwarding select, M stage over W stage
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
            sel = FWD_M;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with data-memory wait and timeout
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);

    hz_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_err_q, mem_err_d;

    logic miss;
    logic lw_stall;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    assign miss     = hz.dmem_req && !hz.dmem_ready;
    assign lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    fwd_sel u_fwd_a (
        .RsE       (hz.Rs1E),
        .RdM       (hz.RdM),
        .RdW       (hz.RdW),
        .RegWriteM (hz.RegWriteM),
        .RegWriteW (hz.RegWriteW),
        .sel       (hz.ForwardAE)
    );

    fwd_sel u_fwd_b (
        .RsE       (hz.Rs2E),
        .RdM       (hz.RdM),
        .RdW       (hz.RdW),
        .RegWriteM (hz.RegWriteM),
        .RegWriteW (hz.RegWriteW),
        .sel       (hz.ForwardBE)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // cnt_q counts INIT cycles, then is reused as the memory wait counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == 8'(INIT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (miss) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (!miss) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'(MEM_TIMEOUT)) begin
                    state_d   = ST_RUN;
                    cnt_d     = 8'd0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (miss) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                    flush_w = 1'b1;
                end else if (state_q == ST_RUN) begin
                    if (hz.PCSrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (lw_stall) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
            default: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
        endcase
    end

    assign hz.StallF  = stall_f;
    assign hz.StallD  = stall_d;
    assign hz.StallE  = stall_e;
    assign hz.StallM  = stall_m;
    assign hz.FlushD  = flush_d;
    assign hz.FlushE  = flush_e;
    assign hz.FlushW  = flush_w;
    assign hz.mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q, retire_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else if (state_q != ST_INIT) begin
            cycle_cnt_q  <= cycle_cnt_q + 1'b1;
            stall_cnt_q  <= stall_cnt_q + CNT_W'(stall_f);
            flush_cnt_q  <= flush_cnt_q + CNT_W'(flush_e);
            retire_cnt_q <= retire_cnt_q + CNT_W'(hz.InstrValidW && !flush_w);
        end
    end

    assign hz.cycle_cnt  = cycle_cnt_q;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;
    assign hz.retire_cnt = retire_cnt_q;
`else
    logic unused_instr_valid;
    assign unused_instr_valid = hz.InstrValidW;

    assign hz.cycle_cnt  = '0;
    assign hz.stall_cnt  = '0;
    assign hz.flush_cnt  = '0;
    assign hz.retire_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int IC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_if #(.CNT_W(32)) hz();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .INIT_CYCLES(IC), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // model: 0 = init, 1 = run, 2 = waiting on memory
    int          m_mode, m_init, m_wait;
    bit          m_err = 1'b0;
    logic [31:0] m_cyc, m_stl, m_fls, m_ret;
    int          e_fa, e_fb;
    logic [3:0]  e_stall;
    logic [2:0]  e_flush;
    logic [3:0]  o_stall;
    logic        o_err;

    function automatic int fwd_ref(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 1;
        return 0;
    endfunction

    task automatic model_outputs();
        bit miss;
        miss    = hz.dmem_req && !hz.dmem_ready;
        e_fa    = fwd_ref(hz.Rs1E);
        e_fb    = fwd_ref(hz.Rs2E);
        e_stall = 4'b0000;
        e_flush = 3'b000;
        if (reset || m_mode == 0) begin
            e_stall = 4'b1000;
            e_flush = 3'b110;
        end else if (miss) begin
            e_stall = 4'b1111;
            e_flush = 3'b001;
        end else if (m_mode == 1) begin
            if (hz.PCSrcE) e_flush = 3'b110;
            else if (hz.ResultSrcE == 2'b01 && hz.RdE != 0 &&
                     (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D)) begin
                e_stall = 4'b1100;
                e_flush = 3'b010;
            end
        end
    endtask

    task automatic step();
        bit miss, err_n;
        @(negedge clk);
        if (reset) begin
            m_mode = 0; m_init = 0; m_wait = 0; m_err = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
        end
        model_outputs();
        o_stall = {hz.StallF, hz.StallD, hz.StallE, hz.StallM};
        o_err   = hz.mem_err;
        chk("fwdA", hz.ForwardAE, e_fa);
        chk("fwdB", hz.ForwardBE, e_fb);
        chk("stall", o_stall, e_stall);
        chk("flush", {hz.FlushD, hz.FlushE, hz.FlushW}, e_flush);
        chk("mem_err", o_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
        chk("cycle_cnt", hz.cycle_cnt, m_cyc);
        chk("stall_cnt", hz.stall_cnt, m_stl);
        chk("flush_cnt", hz.flush_cnt, m_fls);
        chk("retire_cnt", hz.retire_cnt, m_ret);
`else
        chk("cnt_zero", hz.cycle_cnt | hz.stall_cnt | hz.flush_cnt | hz.retire_cnt, 0);
`endif
        miss  = hz.dmem_req && !hz.dmem_ready;
        err_n = 0;
        if (!reset) begin
            if (m_mode != 0) begin
                m_cyc++;
                m_stl += 32'(e_stall[3]);
                m_fls += 32'(e_flush[1]);
                m_ret += 32'(hz.InstrValidW && !e_flush[0]);
            end
            case (m_mode)
                0: begin m_init++; if (m_init == IC) m_mode = 1; end
                1: if (miss) begin m_mode = 2; m_wait = 1; end
                default: begin
                    if (!miss) m_mode = 1;
                    else if (m_wait == TO) begin err_n = 1; m_mode = 1; end
                    else m_wait++;
                end
            endcase
        end
        @(posedge clk);
        m_err = err_n;
        #1;
    endtask

    task automatic clear_inputs();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
        hz.ResultSrcE = 0; hz.PCSrcE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.dmem_req = 0; hz.dmem_ready = 0;
        hz.InstrValidW = 0;
    endtask

    task automatic rand_inputs();
        hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
        hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
        hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
        hz.RdW  = 5'($urandom_range(0, 7));
        hz.ResultSrcE  = 2'($urandom_range(0, 3));
        hz.PCSrcE      = ($urandom_range(0, 5) == 0);
        hz.RegWriteM   = 1'($urandom);
        hz.RegWriteW   = 1'($urandom);
        hz.dmem_req    = ($urandom_range(0, 3) != 0);
        hz.dmem_ready  = ($urandom_range(0, 2) == 0);
        hz.InstrValidW = 1'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    int init_len, stallm_n, err_n, err_at;
    logic [31:0] stl0;

    initial begin
        reset = 1'b1;
        clear_inputs();
        do_reset();

        init_len = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_stall == 4'b1000) init_len++;
        end
        chk("init_len", init_len, IC);
        chk("run_idle", {hz.StallF, hz.FlushD, hz.FlushE}, 3'b000);

        hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
        #1 chk("fwd_m_pri", hz.ForwardAE, 2'b10);
        step();
        hz.RdM = 0;
        #1 chk("fwd_w", hz.ForwardAE, 2'b01);
        step();
        hz.Rs1E = 0; hz.RdW = 0;
        #1 chk("fwd_x0", hz.ForwardAE, 2'b00);
        step();
        clear_inputs();

        hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
        #1 chk("lw_stall", {hz.StallF, hz.StallD, hz.FlushE}, 3'b111);
        step();
        hz.PCSrcE = 1;
        #1 chk("br_pri", {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, 4'b0011);
        step();
        hz.PCSrcE = 0; hz.RdE = 0;
        #1 chk("lw_x0", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);
        step();
        clear_inputs();

        stl0 = hz.stall_cnt;
        stallm_n = 0;
        err_n = 0;
        hz.dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            hz.dmem_ready = (i == 3);
            step();
            if (o_stall[0]) stallm_n++;
            if (hz.mem_err) err_n++;
        end
        chk("mw_stallm", stallm_n, 3);
        chk("mw_no_err", err_n, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("mw_stall_cnt", hz.stall_cnt - stl0, 3);
`endif
        clear_inputs();
        step();

        err_n = 0; err_at = -1;
        hz.dmem_req = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (hz.mem_err) begin err_n++; err_at = i + 1; end
        end
        chk("to_pulses", err_n, 1);
        chk("to_cycle", err_at, 5);
        clear_inputs();
        step();
        chk("to_pulse_len", hz.mem_err, 0);

        err_n = 0;
        hz.dmem_req = 1;
        step();
        step();
        reset = 1'b1;
        #1 chk("rst_abort", {hz.StallF, hz.StallM, hz.FlushD, hz.FlushE}, 4'b1011);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 1) reset = 1'b0;
            if (hz.mem_err) err_n++;
        end
        chk("rst_no_err", err_n, 0);
        clear_inputs();

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        clear_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
